// File: rtl/grf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grf_pkg
// Desc     : Shared types and default parameters for the grf_mp register file.
// Revision : 1.0 - initial release
// ============================================================================
package grf_pkg;

  localparam int C_DATA_W = 32;
  localparam int C_DEPTH  = 32;
  localparam int C_NRD    = 2;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } grf_state_t;

  // Address width never drops below one bit, even for tiny arrays.
  function automatic int grf_addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : grf_scoreboard
// Desc     : Per-register pending bits with set/clear and per-read-port lookup.
// Revision : 1.0 - initial release
// ============================================================================
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int DEPTH  = C_DEPTH,
  parameter int NRD    = C_NRD,
  parameter int ADDR_W = grf_addr_w(C_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_set,
  input  logic [ADDR_W-1:0]     i_set_addr,
  input  logic                  i_clr0,
  input  logic [ADDR_W-1:0]     i_clr0_addr,
  input  logic                  i_clr1,
  input  logic [ADDR_W-1:0]     i_clr1_addr,
  input  logic [NRD*ADDR_W-1:0] i_raddr,
  output logic [NRD-1:0]        o_rpend
);

  localparam logic [ADDR_W:0] C_DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;

  // Callers only raise set/clear for in-range addresses; set is applied last so it wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr0) w_pend_nxt[i_clr0_addr] = 1'b0;
    if (i_clr1) w_pend_nxt[i_clr1_addr] = 1'b0;
    if (i_set)  w_pend_nxt[i_set_addr]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_pend <= '0;
    else        r_pend <= w_pend_nxt;
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      assign w_ra       = i_raddr[k*ADDR_W +: ADDR_W];
      assign o_rpend[k] = ({1'b0, w_ra} < C_DEPTH_X) ? r_pend[w_ra] : 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/grf_mp.sv
`default_nettype none
// ============================================================================
// Module   : grf_mp
// Desc     : Multi-read, dual-write register file with self-clearing init and
//            a pending-write scoreboard. Option GRF_BYPASS_EN adds same-cycle
//            write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module grf_mp
  import grf_pkg::*;
#(
  parameter  int DATA_W = C_DATA_W,
  parameter  int DEPTH  = C_DEPTH,
  parameter  int NRD    = C_NRD,
  localparam int ADDR_W = grf_addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_busy,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rpend,
  input  logic                  sb_set,
  input  logic [ADDR_W-1:0]     sb_addr
);

  localparam logic [ADDR_W:0]   C_DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_LAST    = ADDR_W'(DEPTH - 1);

  grf_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_ready;
  logic              w_wr0, w_wr1, w_sb;
  logic [NRD-1:0]    w_sb_pend;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({1'b0, a} < C_DEPTH_X);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
        if (r_clr_cnt == C_LAST) begin
          w_state_nxt   = READY;
          w_clr_cnt_nxt = '0;
        end
      end
      READY: begin
        w_state_nxt = READY;
      end
    endcase
  end

  // Holding reset low masks everything immediately, before the first edge lands.
  assign w_ready   = reset && (r_state == READY);
  assign init_busy = !w_ready;

  assign w_wr0 = w_ready && we0    && in_range(waddr0);
  assign w_wr1 = w_ready && we1    && in_range(waddr1);
  assign w_sb  = w_ready && sb_set && in_range(sb_addr);

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      if (w_wr0) r_mem[waddr0] <= wdata0;
      if (w_wr1) r_mem[waddr1] <= wdata1;
    end
  end

  grf_scoreboard #(
    .DEPTH  (DEPTH),
    .NRD    (NRD),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .i_set       (w_sb),
    .i_set_addr  (sb_addr),
    .i_clr0      (w_wr0),
    .i_clr0_addr (waddr0),
    .i_clr1      (w_wr1),
    .i_clr1_addr (waddr1),
    .i_raddr     (raddr),
    .o_rpend     (w_sb_pend)
  );

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_data;
      logic              w_pend;

      assign w_ra = raddr[k*ADDR_W +: ADDR_W];

      always_comb begin
        w_data = '0;
        w_pend = 1'b0;
        if (w_ready && in_range(w_ra)) begin
          w_data = r_mem[w_ra];
          w_pend = w_sb_pend[k];
`ifdef GRF_BYPASS_EN
          if (w_wr1 && (waddr1 == w_ra)) begin
            w_data = wdata1;
            w_pend = w_sb && (sb_addr == w_ra);
          end else if (w_wr0 && (waddr0 == w_ra)) begin
            w_data = wdata0;
            w_pend = w_sb && (sb_addr == w_ra);
          end
`endif
        end
      end

      assign rdata[k*DATA_W +: DATA_W] = w_data;
      assign rpend[k]                  = w_pend;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_grf_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_grf_mp
// Desc     : Randomized and directed bench for grf_mp, two configurations
//            (DEPTH 32 / NRD 2 and DEPTH 24 / NRD 3) driven in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grf_mp;

  logic        clk = 1'b0;
  logic        reset, we0, we1, sb_set;
  logic [4:0]  waddr0, waddr1, sb_addr;
  logic [31:0] wdata0, wdata1;
  logic [4:0]  ra [3];

  logic        busy_a, busy_b;
  logic [63:0] rdata_a;
  logic [95:0] rdata_b;
  logic [1:0]  rpend_a;
  logic [2:0]  rpend_b;
  logic [9:0]  raddr_a;
  logic [14:0] raddr_b;

  assign raddr_a = {ra[1], ra[0]};
  assign raddr_b = {ra[2], ra[1], ra[0]};

  always #5 clk = ~clk;

  grf_mp #(.DATA_W(32), .DEPTH(32), .NRD(2)) u_dut_a (
    .clk(clk), .reset(reset), .init_busy(busy_a),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .raddr(raddr_a), .rdata(rdata_a), .rpend(rpend_a),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  grf_mp #(.DATA_W(32), .DEPTH(24), .NRD(3)) u_dut_b (
    .clk(clk), .reset(reset), .init_busy(busy_b),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .raddr(raddr_b), .rdata(rdata_b), .rpend(rpend_b),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  // Reference model: plain arrays plus a count of clear cycles still owed.
  logic [31:0] m_mem  [2][32];
  bit          m_pend [2][32];
  int          m_left [2];
  int          dep [2] = '{32, 24};
  int          nrd [2] = '{2, 3};
  int          busy_cnt [2];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit acc(input int d, input logic en, input logic [4:0] a);
    return en && (a != 0) && (int'(a) < dep[d]);
  endfunction

  function automatic bit ready(input int d);
    return reset && (m_left[d] == 0);
  endfunction

  function automatic logic [31:0] exp_rd(input int d, input logic [4:0] a);
    if (!ready(d) || a == 0 || int'(a) >= dep[d]) return 32'h0;
`ifdef GRF_BYPASS_EN
    if (acc(d, we1, waddr1) && waddr1 == a) return wdata1;
    if (acc(d, we0, waddr0) && waddr0 == a) return wdata0;
`endif
    return m_mem[d][a];
  endfunction

  function automatic bit exp_pend(input int d, input logic [4:0] a);
    if (!ready(d) || a == 0 || int'(a) >= dep[d]) return 1'b0;
`ifdef GRF_BYPASS_EN
    if ((acc(d, we1, waddr1) && waddr1 == a) || (acc(d, we0, waddr0) && waddr0 == a))
      return acc(d, sb_set, sb_addr) && sb_addr == a;
`endif
    return m_pend[d][a];
  endfunction

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        m_left[d] = dep[d];
        for (int i = 0; i < 32; i++) begin
          m_mem[d][i]  = 32'h0;
          m_pend[d][i] = 1'b0;
        end
      end else if (m_left[d] > 0) begin
        m_left[d]--;
      end else begin
        if (acc(d, we0, waddr0)) begin m_mem[d][waddr0] = wdata0; m_pend[d][waddr0] = 1'b0; end
        if (acc(d, we1, waddr1)) begin m_mem[d][waddr1] = wdata1; m_pend[d][waddr1] = 1'b0; end
        if (acc(d, sb_set, sb_addr)) m_pend[d][sb_addr] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check("busy_a", busy_a, !ready(0));
    check("busy_b", busy_b, !ready(1));
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < nrd[d]; k++) begin
        check($sformatf("rdata%0d_%0d", d, k),
              (d == 0) ? rdata_a[k*32 +: 32] : rdata_b[k*32 +: 32], exp_rd(d, ra[k]));
        check($sformatf("rpend%0d_%0d", d, k),
              (d == 0) ? rpend_a[k] : rpend_b[k], exp_pend(d, ra[k]));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    if (busy_a) busy_cnt[0]++;
    if (busy_b) busy_cnt[1]++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; sb_set = 0;
    waddr0 = 0; waddr1 = 0; sb_addr = 0;
    wdata0 = 0; wdata1 = 0;
  endtask

  task automatic rand_inputs();
    we0     = 1'($urandom);
    we1     = 1'($urandom);
    waddr0  = 5'($urandom);
    waddr1  = ($urandom_range(0, 3) == 0) ? waddr0 : 5'($urandom);
    wdata0  = $urandom;
    wdata1  = $urandom;
    sb_set  = ($urandom_range(0, 3) == 0);
    sb_addr = ($urandom_range(0, 1) == 0) ? waddr0 : 5'($urandom);
    for (int k = 0; k < 3; k++)
      ra[k] = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? waddr0 : waddr1)
                                          : 5'($urandom);
  endtask

  // Release reset and count how long each instance reports busy.
  task automatic measure_clear();
    busy_cnt[0] = 0;
    busy_cnt[1] = 0;
    reset = 1'b1;
    repeat (40) begin
      rand_inputs();
      step();
    end
    check("busy_len_a", busy_cnt[0], 32);
    check("busy_len_b", busy_cnt[1], 24);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) ra[k] = 5'd0;
    @(posedge clk);
    model_update();
    #1;
    measure_clear();

    // Simple write, next-cycle read
    idle(); ra[0] = 5; ra[1] = 0; ra[2] = 5;
    we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    step();
    idle();
    #1 check("wr5_a", rdata_a[31:0], 32'hDEADBEEF);
    check("wr5_b", rdata_b[95:64], 32'hDEADBEEF);
    step();

    // Same-address collision, and address 0 write
    we0 = 1; waddr0 = 7; wdata0 = 32'h11; we1 = 1; waddr1 = 7; wdata1 = 32'h22;
    step();
    idle(); ra[0] = 7;
    #1 check("collide7", rdata_a[31:0], 32'h22);
    we0 = 1; waddr0 = 0; wdata0 = 32'hFF;
    step();
    idle(); ra[1] = 0;
    #1 check("addr0", rdata_a[63:32], 32'h0);

    // Scoreboard set / clear / set-wins
    sb_set = 1; sb_addr = 3; ra[0] = 3;
    step();
    idle();
    #1 check("pend3_set", rpend_a[0], 1'b1);
    we0 = 1; waddr0 = 3; wdata0 = 32'h33;
    step();
    idle();
    #1 check("pend3_clr", rpend_a[0], 1'b0);
    sb_set = 1; sb_addr = 3; we1 = 1; waddr1 = 3; wdata1 = 32'h44;
    step();
    idle();
    #1 check("pend3_setwins", rpend_a[0], 1'b1);
    step();

    // Out-of-range for DEPTH 24, and three distinct ports
    we0 = 1; waddr0 = 28; wdata0 = 32'hABCD;
    step();
    idle(); ra[2] = 28;
    #1 check("b_addr28", rdata_b[95:64], 32'h0);
    check("a_addr28", rdata_a[31:0], exp_rd(0, ra[0]));
    we0 = 1; waddr0 = 1; wdata0 = 32'h101; we1 = 1; waddr1 = 2; wdata1 = 32'h202;
    step();
    idle();
    we0 = 1; waddr0 = 23; wdata0 = 32'h2323;
    step();
    idle(); ra[0] = 1; ra[1] = 2; ra[2] = 23;
    #1 check("b_p0", rdata_b[31:0], 32'h101);
    check("b_p1", rdata_b[63:32], 32'h202);
    check("b_p2", rdata_b[95:64], 32'h2323);
    step();

    // Reset in the middle of a clear restarts it
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (10) begin rand_inputs(); step(); end
    reset = 1'b0;
    rand_inputs();
    step();
    measure_clear();

    // Randomized traffic with occasional resets
    repeat (800) begin
      rand_inputs();
      reset = ($urandom_range(0, 199) != 0);
      step();
    end
    reset = 1'b1;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/grf_mp.md
GRF_MP -- requirements
Module: grf_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, register count (2..256, power of two not required).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL derive ADDR_W = clog2(DEPTH), minimum 1.
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous and active-low.
REQ-007 SHALL have port init_busy  out  1  high while the register array is being cleared.
REQ-008 SHALL have ports we0/we1  in  1 each  write enables; port 1 has priority.
REQ-009 SHALL have ports waddr0/waddr1  in  ADDR_W each  write addresses.
REQ-010 SHALL have ports wdata0/wdata1  in  DATA_W each  write data.
REQ-011 SHALL have port raddr  in  NRD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port rdata  out  NRD*DATA_W  packed read data, same packing.
REQ-013 SHALL have port rpend  out  NRD  pending flag of each read port's addressed register.
REQ-014 SHALL have ports sb_set  in  1 and sb_addr  in  ADDR_W  scoreboard mark-pending request.

Function
REQ-015 SHALL implement two-state FSM: CLEAR and READY.
REQ-016 In CLEAR SHALL write 0 to entry clr_cnt each cycle and increment clr_cnt; at clr_cnt == DEPTH-1 SHALL go to READY next edge; CLEAR lasts exactly DEPTH cycles.
REQ-017 SHALL drive init_busy = 1 in CLEAR, 0 in READY.
REQ-018 In CLEAR SHALL ignore we0, we1 and sb_set, and drive rdata = 0 and rpend = 0.
REQ-019 In READY, weK with waddrK != 0 and waddrK < DEPTH SHALL update that entry at the edge; visible on rdata from the next cycle.
REQ-020 we0 and we1 to the same address in one cycle SHALL store wdata1 only.
REQ-021 Entry 0 SHALL read 0 always; writes to address 0 and to addresses >= DEPTH SHALL be dropped.
REQ-022 Reads SHALL be combinational; raddr of 0 or >= DEPTH SHALL return 0 and rpend 0.
REQ-023 sb_set in READY with sb_addr != 0 and < DEPTH SHALL set pend[sb_addr] at the edge.
REQ-024 An accepted write to address A SHALL clear pend[A] at the edge.
REQ-025 sb_set and a write to the same address in one cycle SHALL leave pend set (set wins).
REQ-026 rpend[k] SHALL equal pend[raddr k] (registered value, no bypass).

Reset
REQ-027 reset low at a rising edge SHALL force CLEAR, clr_cnt = 0, all pend = 0, regardless of state, including mid-CLEAR (clear restarts).
REQ-028 After reset is released, init_busy SHALL stay 1 for DEPTH cycles, then drop; all entries read 0.
REQ-029 Outputs while reset is held: init_busy = 1, rdata = 0, rpend = 0.

Configuration
REQ-030 Macro GRF_BYPASS_EN defined: in READY a read whose address matches an accepted same-cycle write SHALL return that write's wdata (port 1 priority), and rpend SHALL read 0 for that address unless sb_set targets it in the same cycle.
REQ-031 GRF_BYPASS_EN undefined: reads SHALL return the pre-edge stored value; no forwarding logic present.

Structure
REQ-032 Package grf_pkg SHALL hold the state enum (CLEAR, READY) and default parameter constants.
REQ-033 Scoreboard (pend vector, set/clear, per-port lookup) SHALL be sub-module grf_scoreboard; the array and FSM stay in grf_mp.

Verification
REQ-034 Reset low 1 cycle, then release, DEPTH=32 -> init_busy high exactly 32 cycles; every raddr reads 0.
REQ-035 READY: we0=1 waddr0=5 wdata0=0xDEADBEEF -> next cycle raddr0=5 reads 0xDEADBEEF; same cycle reads 0xDEADBEEF only with GRF_BYPASS_EN.
REQ-036 we0 waddr0=7 wdata0=0x11, we1 waddr1=7 wdata1=0x22 same cycle -> entry 7 reads 0x22; write to addr 0 of 0xFF -> reads 0.
REQ-037 sb_set sb_addr=3 -> rpend for raddr=3 is 1; later write to 3 -> rpend 0; sb_set and write to 3 same cycle -> rpend stays 1.
REQ-038 Reset asserted at CLEAR cycle 10 -> clr_cnt restarts; init_busy high 32 cycles after release; writes during CLEAR dropped.
REQ-039 DEPTH=24, NRD=3: write to address 28 dropped; raddr 28 reads 0; three ports read distinct entries 1, 2, 23 correctly.
